sdram_rmw_master: RTL
=====================

Name: sdram_rmw_master

Overview:
Parametrised Avalon-MM read-modify-write master for the SDRAM controller port. On a start pulse it walks word_count consecutive words from base_addr. For each word it reads the data, applies the selected operation, and writes the result back to the same address. Control logic or the HPS bridge drives it through a start/busy/done handshake. It generalises the fixed single-word increment loop to any width, length and operation.

Parameters:
DATA_W, 16, data bus width in bits; must be a multiple of 8.
ADDR_W, 32, byte address width.
LEN_W, 16, width of the word_count field.
TIMEOUT_CYC, 255, cycles to wait for readdatavalid; used only with the optional feature.

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  ADDR_W  first byte address; latched on start
word_count  in  LEN_W  number of words to process; latched on start
op_mode  in  2  00 add, 01 xor, 10 fill, 11 invert; latched on start
operand  in  DATA_W  operand for add/xor/fill; latched on start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at completion
words_done  out  LEN_W  count of write-backs accepted in the current/last job
timeout  out  1  sticky error flag (optional feature only, else tied 0)
chipselect  out  1  Avalon chipselect
read_n  out  1  Avalon read, active low
write_n  out  1  Avalon write, active low
address  out  ADDR_W  Avalon byte address
byteenable  out  DATA_W/8  all ones whenever read or write is asserted, else 0
writedata  out  DATA_W  Avalon write data
waitrequest  in  1  slave stall
readdata  in  DATA_W  read data
readdatavalid  in  1  read data qualifier

Behaviour:
- Reset values, applied asynchronously:
  - state IDLE
  - read_n=1, write_n=1, chipselect=0, byteenable=0, address=0, writedata=0
  - busy=0, done=0, words_done=0, timeout=0
- IDLE, start=1:
  - latch all job inputs; cur_addr=base_addr, remaining=word_count, words_done=0; busy=1 next cycle.
  - If word_count=0: go to DONE with no bus cycle.
  - Else if op_mode=10: go to WR_REQ.
  - Else: go to RD_REQ.
- RD_REQ: chipselect=1, read_n=0, address=cur_addr. Hold all three until a cycle with waitrequest=0, then deassert read_n and go to RD_WAIT.
- RD_WAIT: wait for readdatavalid=1 and capture readdata. readdatavalid is ignored in every other state.
- MODIFY (1 cycle) computes the result:
  - add: (rd + operand) mod 2^DATA_W, carry discarded.
  - xor: rd ^ operand.
  - invert: ~rd.
  - fill: operand (reached directly from IDLE/NEXT, no read issued).
- WR_REQ: chipselect=1, write_n=0, address=cur_addr, writedata=result. Hold stable until waitrequest=0; on that cycle words_done increments and the block goes to NEXT.
- NEXT (1 cycle):
  - chipselect=0, write_n=1.
  - cur_addr += DATA_W/8, wrapping modulo 2^ADDR_W.
  - remaining -= 1.
  - If remaining becomes 0, go to DONE; else go to RD_REQ (or WR_REQ for fill).
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Per-word latency with zero wait states and readdatavalid one cycle after accept: 5 cycles (RD_REQ, RD_WAIT, MODIFY, WR_REQ, NEXT); fill takes 2.
- Simultaneous events:
  - start while busy is ignored.
  - start in the DONE cycle is ignored; it is accepted in IDLE only.
  - read_n and write_n are never both 0.
- Reset mid-job: bus strobes drop immediately and the job is abandoned; no resume.

Optional Feature:
Macro SDRAM_RMW_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter runs in RD_WAIT.
  - If TIMEOUT_CYC cycles pass without readdatavalid, set timeout=1 (sticky until next accepted start or reset), go to DONE, and perform no write for that word. words_done reflects completed words only.
- Undefined: RD_WAIT waits indefinitely; timeout is constant 0.

Test Plan:
1. base 0x100, count 3, add, operand 1, mem {5,0xFFFF,7}, no waits -> mem {6,0x0000,8}; 3 reads and 3 writes at 0x100/0x102/0x104; words_done=3; done one pulse; 15 cycles busy.
2. count 0, any op -> done pulses, no chipselect, words_done=0.
3. fill, operand 0xA5A5, count 4, waitrequest high 3 cycles on each write -> no reads; address/writedata stable while stalled; 4 words = 0xA5A5.
4. xor 0x00FF on 0x1234, readdatavalid delayed 6 cycles, plus a second start pulse mid-job -> 0x12CB written; second start ignored; one done pulse.
5. reset asserted during WR_REQ -> write_n=1, chipselect=0, busy=0 before the next edge; a new start then runs normally.
6. SDRAM_RMW_TIMEOUT_EN, TIMEOUT_CYC=10, readdatavalid never asserted -> timeout=1 after 10 RD_WAIT cycles, done pulses, no write, words_done=0.

Source files
------------

// File: rtl/sdram_rmw_master.sv
// Avalon-MM read-modify-write master: walks word_count words from base_addr and
// rewrites each with add/xor/fill/invert. Define SDRAM_RMW_TIMEOUT_EN to enable the RD_WAIT watchdog.
module sdram_rmw_master #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      word_count,
  input  logic [1:0]            op_mode,
  input  logic [DATA_W-1:0]     operand,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      words_done,
  output logic                  timeout,
  output logic                  chipselect,
  output logic                  read_n,
  output logic                  write_n,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic [DATA_W-1:0]     writedata,
  input  logic                  waitrequest,
  input  logic [DATA_W-1:0]     readdata,
  input  logic                  readdatavalid
);

  localparam int                BE_W      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BE_W);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_MODIFY, S_WR_REQ, S_NEXT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_XOR  = 2'b01,
    OP_FILL = 2'b10,
    OP_INV  = 2'b11
  } op_e;

  if ((DATA_W % 8) != 0 || DATA_W < 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("sdram_rmw_master: DATA_W must be a non-zero multiple of 8 and TIMEOUT_CYC >= 1");
  end

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic [DATA_W-1:0]   opd_q, opd_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   result_q, result_d;

`ifdef SDRAM_RMW_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                timeout_q, timeout_d;
`endif

  // NOTE: every _d gets its _q value first, so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    words_d  = words_q;
    opd_d    = opd_q;
    rd_d     = rd_q;
    result_d = result_q;
`ifdef SDRAM_RMW_TIMEOUT_EN
    timer_d   = timer_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op_e'(op_mode);
          addr_d   = base_addr;
          remain_d = word_count;
          words_d  = '0;
          opd_d    = operand;
`ifdef SDRAM_RMW_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          if (word_count == '0) begin
            state_d = S_DONE;
          end else if (op_e'(op_mode) == OP_FILL) begin
            result_d = operand;
            state_d  = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (!waitrequest) begin
          state_d = S_RD_WAIT;
`ifdef SDRAM_RMW_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end

      S_RD_WAIT: begin
        if (readdatavalid) begin
          rd_d    = readdata;
          state_d = S_MODIFY;
        end
`ifdef SDRAM_RMW_TIMEOUT_EN
        // The word in flight is abandoned: no write, words_done keeps completed words only.
        else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end

      S_MODIFY: begin
        unique case (op_q)
          OP_ADD:  result_d = rd_q + opd_q;
          OP_XOR:  result_d = rd_q ^ opd_q;
          OP_FILL: result_d = opd_q;
          OP_INV:  result_d = ~rd_q;
        endcase
        state_d = S_WR_REQ;
      end

      S_WR_REQ: begin
        if (!waitrequest) begin
          words_d = words_q + LEN_W'(1);
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        addr_d   = addr_q + ADDR_STEP;
        remain_d = remain_q - LEN_W'(1);
        if (remain_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end else if (op_q == OP_FILL) begin
          state_d = S_WR_REQ;
        end else begin
          state_d = S_RD_REQ;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      addr_q   <= '0;
      remain_q <= '0;
      words_q  <= '0;
      opd_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
`ifdef SDRAM_RMW_TIMEOUT_EN
      timer_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      words_q  <= words_d;
      opd_q    <= opd_d;
      rd_q     <= rd_d;
      result_q <= result_d;
`ifdef SDRAM_RMW_TIMEOUT_EN
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Bus strobes decode straight from the state register, so reset drops them at once.
  assign chipselect = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign read_n     = (state_q != S_RD_REQ);
  assign write_n    = (state_q != S_WR_REQ);
  assign byteenable = chipselect ? {BE_W{1'b1}} : {BE_W{1'b0}};
  assign address    = addr_q;
  assign writedata  = result_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign words_done = words_q;

`ifdef SDRAM_RMW_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
